// File: rtl/bmp_unpack_if.sv
// Control and memory-bus bundle for the BMP pixel unpacker.
// The unpacker is the master: it drives both address buses and the status outputs.
interface bmp_unpack_if;
  logic        start;
  logic        done;
  logic        error;
  logic [31:0] readAddr;
  logic [15:0] readdata;
  logic [31:0] writeAddr;
  logic [15:0] wrdata;
  logic        wren;
  logic [10:0] imgWidth;
  logic [10:0] imgHeight;

  modport master (
    input  start, readdata,
    output done, error, readAddr, writeAddr, wrdata, wren, imgWidth, imgHeight
  );

  modport slave (
    output start, readdata,
    input  done, error, readAddr, writeAddr, wrdata, wren, imgWidth, imgHeight
  );
endinterface

// File: rtl/bmp_unpack.sv
// Parses a 24-bit BMP header, then copies the padded pixel array into a dense
// row-major RGB buffer, one byte every two cycles (read, then capture/write).
//
// state   | meaning
// IDLE    | waiting for start after reset
// HDR_RD  | header byte address on readAddr
// HDR_CAP | header byte captured from readdata
// PIX_RD  | pixel byte address on readAddr
// PIX_WR  | pixel byte written to the output buffer
// DONE    | image unpacked, waiting for start
// ERR     | header rejected, waiting for start
module bmp_unpack #(
  parameter int MAX_WIDTH   = 100,
  parameter int MAX_HEIGHT  = 100,
  parameter int DATA_OFFSET = 54,
  parameter int OUT_BASE    = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  bmp_unpack_if.master bus
);

  typedef enum logic [2:0] {
    IDLE, HDR_RD, HDR_CAP, PIX_RD, PIX_WR, DONE, ERR
  } state_t;

  state_t      state_q,   state_d;
  logic [3:0]  hdr_idx_q, hdr_idx_d;
  logic        sig_ok_q,  sig_ok_d;
  logic        hi_nz_q,   hi_nz_d;
  logic [15:0] w_q,       w_d;
  logic [15:0] h_q,       h_d;
  logic [1:0]  pad_q,     pad_d;
  logic [10:0] x_q,       x_d;
  logic [10:0] y_q,       y_d;
  logic [1:0]  rgb_q,     rgb_d;
  logic [31:0] rd_addr_q, rd_addr_d;
  logic [31:0] wr_addr_q, wr_addr_d;
  logic        wren_q,    wren_d;
  logic        done_q,    done_d;
  logic        error_q,   error_d;
  logic [10:0] img_w_q,   img_w_d;
  logic [10:0] img_h_q,   img_h_d;

  logic [7:0]  byte_in;
  logic [3:0]  hdr_nxt;
  logic        hdr_bad;
  logic        last_col;
  logic        last_row;
  logic        go;
  logic        unused_hi;

  assign byte_in   = bus.readdata[7:0];
  assign unused_hi = ^bus.readdata[15:8];
  assign hdr_nxt   = hdr_idx_q + 4'd1;
  assign last_col  = (x_q == img_w_q - 11'd1);
  assign last_row  = (y_q == img_h_q - 11'd1);
  assign go        = bus.start && (state_q == IDLE || state_q == DONE || state_q == ERR);

  // Evaluated while byte 25 (height MSB) is on readdata, so it is checked directly.
  assign hdr_bad = !sig_ok_q || hi_nz_q || (byte_in != 8'h00) ||
                   (w_q == 16'h0) || (h_q == 16'h0) ||
                   ({16'h0, w_q} > 32'(MAX_WIDTH)) ||
                   ({16'h0, h_q} > 32'(MAX_HEIGHT));

  always_comb begin
    state_d   = state_q;
    hdr_idx_d = hdr_idx_q;
    sig_ok_d  = sig_ok_q;
    hi_nz_d   = hi_nz_q;
    w_d       = w_q;
    h_d       = h_q;
    pad_d     = pad_q;
    x_d       = x_q;
    y_d       = y_q;
    rgb_d     = rgb_q;
    rd_addr_d = rd_addr_q;
    wr_addr_d = wr_addr_q;
    wren_d    = 1'b0;
    done_d    = done_q;
    error_d   = error_q;
    img_w_d   = img_w_q;
    img_h_d   = img_h_q;

    case (state_q)
      HDR_RD: state_d = HDR_CAP;

      HDR_CAP: begin
        case (hdr_idx_q)
          4'd0:    sig_ok_d = (byte_in == 8'h42);
          4'd1:    sig_ok_d = sig_ok_q && (byte_in == 8'h4D);
          4'd2:    w_d[7:0]  = byte_in;
          4'd3:    w_d[15:8] = byte_in;
          4'd6:    h_d[7:0]  = byte_in;
          4'd7:    h_d[15:8] = byte_in;
          4'd4, 4'd5, 4'd8: hi_nz_d = hi_nz_q || (byte_in != 8'h00);
          default: ;
        endcase
        if (hdr_idx_q == 4'd9) begin
          if (hdr_bad) begin
            state_d = ERR;
            error_d = 1'b1;
            done_d  = 1'b1;
          end else begin
            state_d   = PIX_RD;
            img_w_d   = w_q[10:0];
            img_h_d   = h_q[10:0];
            // (4 - 3w mod 4) mod 4 reduces to w mod 4
            pad_d     = w_q[1:0];
            x_d       = 11'd0;
            y_d       = 11'd0;
            rgb_d     = 2'd0;
            rd_addr_d = 32'(DATA_OFFSET);
            wr_addr_d = 32'(OUT_BASE);
          end
        end else begin
          state_d   = HDR_RD;
          hdr_idx_d = hdr_nxt;
          rd_addr_d = {28'h0, hdr_nxt} + ((hdr_nxt >= 4'd2) ? 32'd16 : 32'd0);
        end
      end

      PIX_RD: begin
        state_d = PIX_WR;
        wren_d  = 1'b1;
      end

      PIX_WR: begin
        state_d   = PIX_RD;
        rd_addr_d = rd_addr_q + 32'd1;
        wr_addr_d = wr_addr_q + 32'd1;
        if (rgb_q != 2'd2) begin
          rgb_d = rgb_q + 2'd1;
        end else begin
          rgb_d = 2'd0;
          if (!last_col) begin
            x_d = x_q + 11'd1;
          end else begin
            x_d = 11'd0;
            // Skip the row padding so the next read lands on the next row's first byte.
            rd_addr_d = rd_addr_q + 32'd1 + {30'h0, pad_q};
            if (last_row) begin
              state_d   = DONE;
              done_d    = 1'b1;
              rd_addr_d = rd_addr_q;
              wr_addr_d = wr_addr_q;
            end else begin
              y_d = y_q + 11'd1;
            end
          end
        end
      end

      default: ;
    endcase

    if (go) begin
      state_d   = HDR_RD;
      hdr_idx_d = 4'd0;
      hi_nz_d   = 1'b0;
      rd_addr_d = 32'd0;
      done_d    = 1'b0;
      error_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      hdr_idx_q <= 4'd0;
      sig_ok_q  <= 1'b0;
      hi_nz_q   <= 1'b0;
      w_q       <= 16'h0;
      h_q       <= 16'h0;
      pad_q     <= 2'd0;
      x_q       <= 11'd0;
      y_q       <= 11'd0;
      rgb_q     <= 2'd0;
      rd_addr_q <= 32'd0;
      wr_addr_q <= 32'(OUT_BASE);
      wren_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      img_w_q   <= 11'd0;
      img_h_q   <= 11'd0;
    end else begin
      state_q   <= state_d;
      hdr_idx_q <= hdr_idx_d;
      sig_ok_q  <= sig_ok_d;
      hi_nz_q   <= hi_nz_d;
      w_q       <= w_d;
      h_q       <= h_d;
      pad_q     <= pad_d;
      x_q       <= x_d;
      y_q       <= y_d;
      rgb_q     <= rgb_d;
      rd_addr_q <= rd_addr_d;
      wr_addr_q <= wr_addr_d;
      wren_q    <= wren_d;
      done_q    <= done_d;
      error_q   <= error_d;
      img_w_q   <= img_w_d;
      img_h_q   <= img_h_d;
    end
  end

  assign bus.done      = done_q;
  assign bus.error     = error_q;
  assign bus.readAddr  = rd_addr_q;
  assign bus.writeAddr = wr_addr_q;
  assign bus.wren      = wren_q;
  // Data passes straight through in the write cycle, when the read result is valid.
  assign bus.wrdata    = wren_q ? {8'h00, byte_in} : 16'h0000;
  assign bus.imgWidth  = img_w_q;
  assign bus.imgHeight = img_h_q;

endmodule
